// File: rtl/conv_pkg.sv
// Shared constants and state type for the K=3, rate-1/2 convolutional encode/decode path.
package conv_pkg;
  localparam int SIZE_DATA_IN   = 8;
  localparam int SIZE_DATA_OUT  = 2 * SIZE_DATA_IN;
  localparam int CONSTRAINT_LEN = 3;
  localparam int MEM_W          = CONSTRAINT_LEN - 1;
  localparam int TAIL_W         = 2 * MEM_W;
  localparam int CNT_W          = $clog2(SIZE_DATA_IN);

  localparam logic [CONSTRAINT_LEN-1:0] G0 = 3'b111;
  localparam logic [CONSTRAINT_LEN-1:0] G1 = 3'b101;

  typedef enum logic [1:0] {IDLE, ENC, TAIL, DONE} enc_state_e;
endpackage

// File: rtl/conv_encoder_frame_if.sv
// Frame request / codeword result bundle between the data source and conv_encoder_frame.
interface conv_encoder_frame_if;
  import conv_pkg::*;

  logic                     i_start;
  logic [SIZE_DATA_IN-1:0]  i_data;
  logic                     o_busy;
  logic [SIZE_DATA_OUT-1:0] o_data;
  logic [TAIL_W-1:0]        o_tail;
  logic                     o_done;

  modport master (output i_start, i_data, input o_busy, o_data, o_tail, o_done);
  modport slave  (input i_start, i_data, output o_busy, o_data, o_tail, o_done);
endinterface

// File: rtl/conv_enc_core.sv
// Generator XOR network: one input bit plus encoder memory {d1,d2} -> 2-bit symbol.
module conv_enc_core
  import conv_pkg::*;
(
  input  logic             in_bit,
  input  logic [MEM_W-1:0] mem,
  output logic [1:0]       sym
);
  logic [CONSTRAINT_LEN-1:0] sr;

  assign sr  = {in_bit, mem};
  assign sym = {^(sr & G0), ^(sr & G1)};
endmodule

// File: rtl/conv_encoder_frame.sv
// Frame-level K=3 rate-1/2 encoder: 8-bit word in, 16-bit codeword out, MSB first.
// Build option TAIL_FLUSH_EN: flush K-1 zero bits per frame and report their symbols on o_tail.
module conv_encoder_frame
  import conv_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst,
  conv_encoder_frame_if.slave bus
);
  localparam logic [CNT_W-1:0] ENC_LAST = CNT_W'(SIZE_DATA_IN - 1);

  enc_state_e               state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [SIZE_DATA_IN-1:0]  payload_q, payload_d;
  logic [MEM_W-1:0]         mem_q, mem_d;
  logic [SIZE_DATA_OUT-1:0] pack_q, pack_d;
  logic [SIZE_DATA_OUT-1:0] o_data_q, o_data_d;
  logic                     core_bit;
  logic [1:0]               sym;

  // Outside ENC the core sees a zero bit, which is exactly the tail flush input.
  assign core_bit = (state_q == ENC) ? payload_q[SIZE_DATA_IN-1] : 1'b0;

  conv_enc_core u_core (
    .in_bit (core_bit),
    .mem    (mem_q),
    .sym    (sym)
  );

`ifdef TAIL_FLUSH_EN
  localparam logic [CNT_W-1:0] TAIL_LAST = CNT_W'(MEM_W - 1);
  logic [TAIL_W-1:0] tail_q, tail_d;
  logic [TAIL_W-1:0] o_tail_q, o_tail_d;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    payload_d = payload_q;
    mem_d     = mem_q;
    pack_d    = pack_q;
    o_data_d  = o_data_q;
`ifdef TAIL_FLUSH_EN
    tail_d    = tail_q;
    o_tail_d  = o_tail_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.i_start) begin
          payload_d = bus.i_data;
          cnt_d     = '0;
          state_d   = ENC;
        end
      end
      ENC: begin
        payload_d = {payload_q[SIZE_DATA_IN-2:0], 1'b0};
        mem_d     = {core_bit, mem_q[MEM_W-1:1]};
        pack_d    = {pack_q[SIZE_DATA_OUT-3:0], sym};
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == ENC_LAST) begin
          cnt_d = '0;
`ifdef TAIL_FLUSH_EN
          state_d = TAIL;
`else
          state_d  = DONE;
          o_data_d = pack_d;
`endif
        end
      end
`ifdef TAIL_FLUSH_EN
      TAIL: begin
        mem_d  = {core_bit, mem_q[MEM_W-1:1]};
        tail_d = {tail_q[TAIL_W-3:0], sym};
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == TAIL_LAST) begin
          cnt_d    = '0;
          state_d  = DONE;
          o_data_d = pack_q;
          o_tail_d = tail_d;
        end
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      payload_q <= '0;
      mem_q     <= '0;
      pack_q    <= '0;
      o_data_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      payload_q <= payload_d;
      mem_q     <= mem_d;
      pack_q    <= pack_d;
      o_data_q  <= o_data_d;
    end
  end

`ifdef TAIL_FLUSH_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      tail_q   <= '0;
      o_tail_q <= '0;
    end else begin
      tail_q   <= tail_d;
      o_tail_q <= o_tail_d;
    end
  end
  assign bus.o_tail = o_tail_q;
`else
  assign bus.o_tail = '0;
`endif

  assign bus.o_data = o_data_q;
  assign bus.o_busy = (state_q != IDLE);
  assign bus.o_done = (state_q == DONE);
endmodule

// File: tb/tb_conv_encoder_frame.sv
// Self-checking bench for conv_encoder_frame: directed spec cases plus random frames vs a trellis model.
module tb_conv_encoder_frame;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

`ifdef TAIL_FLUSH_EN
  localparam int LAT = 11;
`else
  localparam int LAT = 9;
`endif

  conv_encoder_frame_if bus ();

  conv_encoder_frame dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference encoder state: previous two input bits, most recent first.
  logic [1:0] model_st = 2'b00;
  logic [3:0] model_tail;

  function automatic logic [1:0] gen_sym(input logic b, input logic [1:0] st);
    logic [2:0] reg3;
    logic s1, s0;
    reg3 = {b, st};
    s1 = ($countones(reg3 & 3'o7) % 2) == 1;
    s0 = ($countones(reg3 & 3'o5) % 2) == 1;
    return {s1, s0};
  endfunction

  function automatic logic [15:0] model_frame(input logic [7:0] d);
    logic [15:0] cw;
    cw = '0;
    for (int i = 7; i >= 0; i--) begin
      cw = {cw[13:0], gen_sym(d[i], model_st)};
      model_st = {d[i], model_st[1]};
    end
    model_tail = '0;
`ifdef TAIL_FLUSH_EN
    for (int i = 0; i < 2; i++) begin
      model_tail = {model_tail[1:0], gen_sym(1'b0, model_st)};
      model_st = {1'b0, model_st[1]};
    end
`endif
    return cw;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_busy", 32'(bus.o_busy), 32'd0);
    chk("rst_done", 32'(bus.o_done), 32'd0);
    chk("rst_data", 32'(bus.o_data), 32'd0);
    chk("rst_tail", 32'(bus.o_tail), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_st = 2'b00;
  endtask

  // Runs one frame; pulse_mask bit c raises i_start (random data) during frame cycle c.
  task automatic run_frame(input string tag, input logic [7:0] d, input logic [31:0] pulse_mask,
                           output logic [15:0] got);
    logic [15:0] exp_cw;
    logic [3:0]  exp_tail;
    int c;
    exp_cw   = model_frame(d);
    exp_tail = model_tail;
    @(negedge clk);
    bus.i_start = 1'b1;
    bus.i_data  = d;
    @(posedge clk);
    #1;
    c = 1;
    chk({tag, "_busy1"}, 32'(bus.o_busy), 32'd1);
    forever begin
      bus.i_start = pulse_mask[c];
      bus.i_data  = 8'($urandom);
      if (bus.o_done || c >= 30) break;
      @(posedge clk);
      #1;
      c++;
    end
    got = bus.o_data;
    chk({tag, "_lat"}, 32'(c), 32'(LAT));
    chk({tag, "_data"}, 32'(bus.o_data), 32'(exp_cw));
    chk({tag, "_tail"}, 32'(bus.o_tail), 32'(exp_tail));
    $display("frame %s: in=%02h out=%04h tail=%0h latency=%0d", tag, d, bus.o_data, bus.o_tail, c);
    @(posedge clk);
    #1;
    bus.i_start = 1'b0;
    chk({tag, "_idle_done"}, 32'(bus.o_done), 32'd0);
    chk({tag, "_idle_busy"}, 32'(bus.o_busy), 32'd0);
    if (pulse_mask != 0) begin
      @(posedge clk);
      #1;
      chk({tag, "_no_queue"}, 32'(bus.o_busy), 32'd0);
      chk({tag, "_held"}, 32'(bus.o_data), 32'(exp_cw));
    end
  endtask

  initial begin
    logic [15:0] got;
    int n_done;
    int t_first, t_second;
    logic [15:0] d_first, d_second, e_first, e_second;

    bus.i_start = 1'b0;
    bus.i_data  = 8'h00;
    do_reset();

    run_frame("t1_zero", 8'h00, 0, got);
    chk("t1_const", 32'(got), 32'h0000);

    do_reset();
    run_frame("t2_ones", 8'hFF, 0, got);
    chk("t2_const", 32'(got), 32'hDAAA);
`ifdef TAIL_FLUSH_EN
    chk("t2_tail_const", 32'(bus.o_tail), 32'h7);
`endif

    do_reset();
    run_frame("t3_impulse", 8'h80, 0, got);
    chk("t3_const", 32'(got), 32'hEC00);

    do_reset();
    run_frame("t4_a", 8'hFF, 0, got);
    run_frame("t4_b", 8'h00, 0, got);
`ifdef TAIL_FLUSH_EN
    chk("t4_const", 32'(got), 32'h0000);
`else
    chk("t4_const", 32'(got), 32'h7000);
`endif

    run_frame("t5_ignore", 8'hA5, (32'd1 << 3) | (32'd1 << 9) | (32'd1 << LAT), got);

    // Abort a frame with an asynchronous reset in ENC cycle 4.
    @(negedge clk);
    bus.i_start = 1'b1;
    bus.i_data  = 8'h5A;
    @(posedge clk);
    #1;
    bus.i_start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("t6_busy", 32'(bus.o_busy), 32'd0);
    chk("t6_data", 32'(bus.o_data), 32'd0);
    chk("t6_tail", 32'(bus.o_tail), 32'd0);
    chk("t6_done", 32'(bus.o_done), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_st = 2'b00;
    n_done = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      if (bus.o_done) n_done++;
    end
    chk("t6_no_done", 32'(n_done), 32'd0);
    run_frame("t6_after", 8'h80, 0, got);
    chk("t6_const", 32'(got), 32'hEC00);

    // i_start held high: back-to-back frames with one IDLE cycle in between.
    e_first  = model_frame(8'h3C);
    e_second = model_frame(8'h3C);
    @(negedge clk);
    bus.i_start = 1'b1;
    bus.i_data  = 8'h3C;
    t_first  = -1;
    t_second = -1;
    d_first  = '0;
    d_second = '0;
    for (int c = 1; c <= 60 && t_second < 0; c++) begin
      @(posedge clk);
      #1;
      if (bus.o_done) begin
        if (t_first < 0) begin
          t_first = c;
          d_first = bus.o_data;
        end else begin
          t_second = c;
          d_second = bus.o_data;
          bus.i_start = 1'b0;
        end
      end
    end
    bus.i_start = 1'b0;
    $display("b2b: first done cycle %0d data %04h, second done cycle %0d data %04h",
             t_first, d_first, t_second, d_second);
    chk("b2b_first_lat", 32'(t_first), 32'(LAT));
    chk("b2b_interval", 32'(t_second - t_first), 32'(LAT + 1));
    chk("b2b_first_data", 32'(d_first), 32'(e_first));
    chk("b2b_second_data", 32'(d_second), 32'(e_second));
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("b2b_stop", 32'(bus.o_busy), 32'd0);

    for (int i = 0; i < 20; i++) begin
      run_frame($sformatf("rnd%0d", i), 8'($urandom), 0, got);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
